// File: rtl/data_mem_ctrl.sv
// Data-memory controller: owns the pixel/data RAM and serves single-word read/write
// requests with WAIT_STATES read latency. Optional range checking: DMC_ADDR_CHECK_EN.
module data_mem_ctrl #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int DEPTH       = 4096,
    parameter int WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              read_req,
    input  logic              write_req,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              mem_write_en,
    output logic              busy,
    output logic              done
`ifdef DMC_ADDR_CHECK_EN
    ,
    output logic              addr_err
`endif
);

    localparam int         IDX_W     = $clog2(DEPTH);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [3:0]        wait_cnt_reg, wait_cnt_next;
    logic [IDX_W-1:0]  idx_reg, idx_next;
    logic [DATA_W-1:0] wdata_reg, wdata_next;
    logic              err_reg, err_next;

    logic [DATA_W-1:0] rd_data_reg;
    logic              mem_write_en_reg;
    logic              done_reg;
    logic              addr_err_reg;

    logic              ram_we;
    logic              rd_load;
    logic              done_next;
    logic              addr_err_next;
    logic              addr_hi_set;
    logic              req_oor;

    logic [DATA_W-1:0] ram_mem [DEPTH];

    // An address is out of range exactly when any bit above the RAM index is set.
    generate
        if (IDX_W < ADDR_W) begin : g_addr_hi
            assign addr_hi_set = |address[ADDR_W-1:IDX_W];
        end else begin : g_addr_full
            assign addr_hi_set = 1'b0;
        end
    endgenerate

`ifdef DMC_ADDR_CHECK_EN
    assign req_oor = addr_hi_set;
`else
    logic unused_addr_hi;
    assign unused_addr_hi = addr_hi_set;
    assign req_oor        = 1'b0;
`endif

    // State register and latched request context
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            wait_cnt_reg <= 4'd0;
            idx_reg      <= '0;
            wdata_reg    <= '0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            idx_reg      <= idx_next;
            wdata_reg    <= wdata_next;
            err_reg      <= err_next;
        end
    end

    // Next-state logic; a simultaneous read and write resolves to the read.
    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        idx_next      = idx_reg;
        wdata_next    = wdata_reg;
        err_next      = err_reg;
        case (state_reg)
            ST_IDLE: begin
                if (read_req) begin
                    state_next    = ST_READ;
                    idx_next      = address[IDX_W-1:0];
                    err_next      = req_oor;
                    wait_cnt_next = req_oor ? 4'd0 : WAIT_INIT;
                end else if (write_req) begin
                    state_next    = ST_WRITE;
                    idx_next      = address[IDX_W-1:0];
                    wdata_next    = wr_data;
                    err_next      = req_oor;
                    wait_cnt_next = 4'd0;
                end
            end
            ST_READ: begin
                if (wait_cnt_reg != 4'd0) begin
                    wait_cnt_next = wait_cnt_reg - 4'd1;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_WRITE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Output decode: completion actions for the access that finishes this cycle
    always_comb begin
        ram_we        = 1'b0;
        rd_load       = 1'b0;
        done_next     = 1'b0;
        addr_err_next = 1'b0;
        case (state_reg)
            ST_READ: begin
                if (wait_cnt_reg == 4'd0) begin
                    done_next     = 1'b1;
                    addr_err_next = err_reg;
                    rd_load       = !err_reg;
                end
            end
            ST_WRITE: begin
                done_next     = 1'b1;
                addr_err_next = err_reg;
                ram_we        = !err_reg;
            end
            default: begin
                ram_we = 1'b0;
            end
        endcase
    end

    // RAM is never cleared; a reset coinciding with the write edge cancels the write.
    always_ff @(posedge clk) begin
        if (ram_we && !reset) begin
            ram_mem[idx_reg] <= wdata_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_reg      <= '0;
            mem_write_en_reg <= 1'b0;
            done_reg         <= 1'b0;
            addr_err_reg     <= 1'b0;
        end else begin
            mem_write_en_reg <= rd_load;
            done_reg         <= done_next;
            addr_err_reg     <= addr_err_next;
            if (rd_load) begin
                rd_data_reg <= ram_mem[idx_reg];
            end
        end
    end

    assign rd_data      = rd_data_reg;
    assign mem_write_en = mem_write_en_reg;
    assign done         = done_reg;
    assign busy         = (state_reg != ST_IDLE);

`ifdef DMC_ADDR_CHECK_EN
    assign addr_err = addr_err_reg;
`else
    logic unused_addr_err;
    assign unused_addr_err = addr_err_reg;
`endif

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: a WAIT_STATES=2 instance for latency/abort cases
// and a WAIT_STATES=0 instance for back-to-back throughput; both share request inputs.
module tb_data_mem_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        read_req;
    logic        write_req;
    logic [15:0] address;
    logic [15:0] wr_data;

    logic [15:0] rd_data, rd_data0;
    logic        mem_write_en, mem_write_en0;
    logic        busy, busy0;
    logic        done, done0;
`ifdef DMC_ADDR_CHECK_EN
    logic        addr_err, addr_err0;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    data_mem_ctrl #(.DATA_W(16), .ADDR_W(16), .DEPTH(4096), .WAIT_STATES(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .read_req     (read_req),
        .write_req    (write_req),
        .address      (address),
        .wr_data      (wr_data),
        .rd_data      (rd_data),
        .mem_write_en (mem_write_en),
        .busy         (busy),
        .done         (done)
`ifdef DMC_ADDR_CHECK_EN
        ,
        .addr_err     (addr_err)
`endif
    );

    data_mem_ctrl #(.DATA_W(16), .ADDR_W(16), .DEPTH(4096), .WAIT_STATES(0)) dut0 (
        .clk          (clk),
        .reset        (reset),
        .read_req     (read_req),
        .write_req    (write_req),
        .address      (address),
        .wr_data      (wr_data),
        .rd_data      (rd_data0),
        .mem_write_en (mem_write_en0),
        .busy         (busy0),
        .done         (done0)
`ifdef DMC_ADDR_CHECK_EN
        ,
        .addr_err     (addr_err0)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt = total_cnt + 1;
        assert (obs === exp) pass_cnt = pass_cnt + 1;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until the WS=2 instance pulses done, bounded to 20 cycles.
    task automatic wait_done(output int k);
        k = 0;
        do begin
            tick();
            k = k + 1;
        end while (done !== 1'b1 && k < 20);
    endtask

    task automatic do_write(input string tag, input logic [15:0] a, input logic [15:0] d);
        int k;
        address = a; wr_data = d; write_req = 1'b1;
        tick();
        write_req = 1'b0;
        wait_done(k);
        check({tag, "_lat"}, k, 1);
        check({tag, "_mwe"}, mem_write_en, 0);
        $display("write addr=0x%04h data=0x%04h latency=%0d", a, d, k);
    endtask

    task automatic do_read(input string tag, input logic [15:0] a, input logic [15:0] exp);
        int k;
        address = a; read_req = 1'b1;
        tick();
        read_req = 1'b0;
        check({tag, "_busy"}, busy, 1);
        wait_done(k);
        check({tag, "_lat"}, k, 3);
        check({tag, "_mwe"}, mem_write_en, 1);
        check({tag, "_data"}, rd_data, exp);
        check({tag, "_idle"}, busy, 0);
        $display("read  addr=0x%04h data=0x%04h latency=%0d", a, rd_data, k);
    endtask

    initial begin
        int n_done, n_mwe, k;
        logic [15:0] seen;
        reset = 1'b1; read_req = 1'b0; write_req = 1'b0; address = '0; wr_data = '0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_rd_data", rd_data, 0);
        check("rst_mwe", mem_write_en, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
`ifdef DMC_ADDR_CHECK_EN
        check("rst_addr_err", addr_err, 0);
`endif
        $display("reset released");

        do_write("w5", 16'd5, 16'h1234);
        do_read("r5", 16'd5, 16'h1234);
        tick();
        check("r5_done_width", done, 0);
        check("r5_mwe_width", mem_write_en, 0);
        check("r5_hold", rd_data, 16'h1234);

        // Both requests together: read of addr 7 wins, write of 0xDEAD dropped
        do_write("w7", 16'd7, 16'h0777);
        address = 16'd7; wr_data = 16'hDEAD; read_req = 1'b1; write_req = 1'b1;
        tick();
        read_req = 1'b0; write_req = 1'b0;
        n_done = 0; n_mwe = 0; seen = '0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done === 1'b1) begin n_done++; seen = rd_data; end
            if (mem_write_en === 1'b1) n_mwe++;
        end
        check("both_done_cnt", n_done, 1);
        check("both_mwe_cnt", n_mwe, 1);
        check("both_data", seen, 16'h0777);
        $display("both  addr=0x0007 dones=%0d data=0x%04h", n_done, seen);
        do_read("r7", 16'd7, 16'h0777);

        // Read request while busy must be ignored
        address = 16'd5; read_req = 1'b1;
        tick();
        read_req = 1'b0;
        tick();
        address = 16'd7; read_req = 1'b1;
        tick();
        read_req = 1'b0;
        n_done = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done === 1'b1) n_done++;
        end
        check("busy_ign_done_cnt", n_done, 1);
        check("busy_ign_data", rd_data, 16'h1234);
        $display("busy-ignore dones=%0d data=0x%04h", n_done, rd_data);

`ifdef DMC_ADDR_CHECK_EN
        do_write("w3", 16'd3, 16'h0003);
        address = 16'h1003; wr_data = 16'hBEEF; write_req = 1'b1;
        tick();
        write_req = 1'b0;
        wait_done(k);
        check("oor_w_lat", k, 1);
        check("oor_w_err", addr_err, 1);
        tick();
        check("oor_w_err_width", addr_err, 0);
        do_read("r3", 16'd3, 16'h0003);
        address = 16'h1005; read_req = 1'b1;
        tick();
        read_req = 1'b0;
        wait_done(k);
        check("oor_r_lat", k, 1);
        check("oor_r_err", addr_err, 1);
        check("oor_r_mwe", mem_write_en, 0);
        check("oor_r_data", rd_data, 16'h0003);
        $display("oor read addr=0x1005 latency=%0d err=%0b", k, addr_err);
`else
        do_write("wrap_w", 16'h1003, 16'hBEEF);
        do_read("wrap_r", 16'd3, 16'hBEEF);
`endif

        // Reset sampled at the second wait cycle of a read aborts it
        do_write("w9", 16'd9, 16'h5A5A);
        address = 16'd9; read_req = 1'b1;
        tick();
        read_req = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_rd_busy", busy, 0);
        check("rst_rd_mwe", mem_write_en, 0);
        check("rst_rd_done", done, 0);
        check("rst_rd_data", rd_data, 0);
        n_mwe = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (mem_write_en === 1'b1 || done === 1'b1) n_mwe++;
        end
        check("rst_rd_no_strobe", n_mwe, 0);
        $display("reset during read, strobes after=%0d", n_mwe);
        do_read("r9", 16'd9, 16'h5A5A);

        // Reset at the write edge cancels the RAM update
        address = 16'd9; wr_data = 16'hFFFF; write_req = 1'b1;
        tick();
        write_req = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_wr_busy", busy, 0);
        check("rst_wr_done", done, 0);
        $display("reset during write addr=0x0009");
        do_read("r9b", 16'd9, 16'h5A5A);

        // Back-to-back reads on the zero-wait instance
        for (int i = 0; i < 4; i++) do_write("wb2b", 16'(i), 16'(16'hA0 + i));
        address = 16'd0; read_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            read_req = 1'b0;
            check("b2b_req_mwe", mem_write_en0, 0);
            check("b2b_req_busy", busy0, 1);
            tick();
            check("b2b_mwe", mem_write_en0, 1);
            check("b2b_done", done0, 1);
            check("b2b_data", rd_data0, 32'(16'hA0 + i));
            $display("b2b   addr=0x%04h data=0x%04h mwe=%0b", i, rd_data0, mem_write_en0);
            if (i < 3) begin
                address = 16'(i + 1);
                read_req = 1'b1;
            end
        end
        for (int i = 0; i < 8; i++) tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
